// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: req/addr held until ack, data valid in the ack cycle.
interface instr_fetch_unit_if
  import fetch_pkg::*;
();

  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush beats push and pop.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; head is masked to zero while empty, so stale words never escape.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner, memory request FSM and instruction buffer.
// Optional counters enabled by defining FETCH_STATS_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master mem,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [31:0]        inst_pc,
  input  logic               inst_ready,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_dropped,
  output logic [15:0]        stat_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n, drop_addr;
  logic          ack, push, pop, flush;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] count;
  fetch_entry_t  wentry, head;

  assign ack           = mem.mem_req && mem.mem_ack;
  assign mem.mem_req   = (state != IDLE);
  // An abandoned request must keep presenting its original address until acked.
  assign mem.mem_addr  = (state == DROP) ? drop_addr : fetch_pc;
  assign wentry        = {fetch_pc, mem.mem_rdata};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    push       = 1'b0;
    pop        = inst_valid && inst_ready;
    flush      = 1'b0;
    if (redirect) begin
      flush      = 1'b1;
      pop        = 1'b0;
      fetch_pc_n = redirect_pc & ~32'd3;
      case (state)
        IDLE:    state_n = REQ;
        REQ:     state_n = ack ? REQ : DROP;
        DROP:    state_n = ack ? REQ : DROP;
        default: state_n = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: if (!fifo_full) state_n = REQ;
        REQ: if (ack) begin
          push       = 1'b1;
          fetch_pc_n = fetch_pc + PC_INC;
          state_n    = (pop || count < CW'(DEPTH - 1)) ? REQ : IDLE;
        end
        DROP: if (ack) state_n = REQ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (redirect && state == REQ && !ack) drop_addr <= fetch_pc;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wentry),
    .head  (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
      stat_flushes <= '0;
    end else begin
      if (push && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
      if (ack && (redirect || state == DROP) && stat_dropped != '1)
        stat_dropped <= stat_dropped + 32'd1;
      if (redirect && stat_flushes != '1) stat_flushes <= stat_flushes + 16'd1;
    end
  end
`endif

endmodule
